// File: rtl/choose_pkg.sv
// Shared types for the multi-player keep/discard chooser.
package choose_pkg;

  typedef enum logic [1:0] {
    CONTINUE = 2'd0,
    LOST     = 2'd1,
    WON      = 2'd2
  } result_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CHOOSE,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/choose_multi_turn_timer.sv
// Saturating CHOOSE-state cycle counter; a clear loads 1 so the first counted cycle reads 1.
module turn_timer #(
  parameter int TIMEOUT = 0,
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= TW'(1);
    end else if (en && (count != TW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // A zero TIMEOUT disables expiry entirely.
  assign expired = (TIMEOUT > 0) && (count == TW'(TIMEOUT));

endmodule

// File: rtl/choose_multi.sv
// Multi-player keep/discard decision controller: holds per-player scores and the turn pointer,
// resolves each roll as auto-keep, player choice or timeout discard, and pulses the outcome.
module choose_multi
  import choose_pkg::*;
#(
  parameter int NPLAYERS  = 2,
  parameter int TARGET    = 15,
  parameter int NUM_W     = 3,
  parameter int SCORE_W   = 5,
  parameter int AUTO_FACE = 6,
  parameter int TIMEOUT   = 0,
  localparam int PW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse_i,
  input  logic [NUM_W-1:0]   num,
  input  logic               choice,
  input  logic               confirm,
  output logic [1:0]         result,
  output logic               pulse_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [PW-1:0]      player_o,
  output logic               busy
);

  state_t               state;
  logic [NUM_W-1:0]     num_q;
  logic [SCORE_W-1:0]   score [NPLAYERS];
  logic                 confirm_q;
  logic                 rise;
  logic                 expired;
  logic [SCORE_W:0]     sum;
  result_t              keep_res;
  logic [SCORE_W-1:0]   keep_score;
  logic                 do_res;
  logic                 do_keep;
  result_t              res_kind;
  logic [SCORE_W-1:0]   new_score;

  turn_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == CHECK),
    .en      (state == CHOOSE),
    .expired (expired)
  );

  assign rise = confirm & ~confirm_q;

  // Resolution outcome for the current player, evaluated every cycle and applied when do_res is set.
  always_comb begin
    sum        = {1'b0, score[player_o]} + (SCORE_W + 1)'(num_q);
    keep_res   = CONTINUE;
    keep_score = sum[SCORE_W-1:0];
    if (sum > (SCORE_W + 1)'(TARGET)) begin
      keep_res   = LOST;
      keep_score = '0;
    end else if (sum == (SCORE_W + 1)'(TARGET)) begin
      keep_res   = WON;
      keep_score = SCORE_W'(TARGET);
    end

    do_res  = 1'b0;
    do_keep = 1'b0;
    case (state)
      CHECK: begin
        do_res  = (num_q == NUM_W'(AUTO_FACE));
        do_keep = 1'b1;
      end
      CHOOSE: begin
        do_res  = expired & ~rise;
        do_keep = 1'b0;
      end
      RELEASE: begin
        do_res  = ~confirm;
        do_keep = choice;
      end
      default: begin
        do_res  = 1'b0;
        do_keep = 1'b0;
      end
    endcase

    res_kind  = do_keep ? keep_res : CONTINUE;
    new_score = do_keep ? keep_score : score[player_o];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_q     <= '0;
      confirm_q <= 1'b0;
      pulse_o   <= 1'b0;
      result    <= CONTINUE;
      score_o   <= '0;
      player_o  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NPLAYERS; i++) score[i] <= '0;
    end else begin
      confirm_q <= confirm;
      pulse_o   <= 1'b0;
      result    <= CONTINUE;

      case (state)
        IDLE: if (pulse_i) begin
          num_q <= num;
          state <= CHECK;
          busy  <= 1'b1;
        end
        CHECK:   state <= CHOOSE;
        CHOOSE:  if (rise) state <= RELEASE;
        RELEASE: state <= RELEASE;
        default: state <= DONE;
      endcase

      // A resolution overrides the plain transitions above.
      if (do_res) begin
        pulse_o          <= 1'b1;
        result           <= res_kind;
        score_o          <= new_score;
        score[player_o]  <= new_score;
        if (res_kind == CONTINUE) begin
          state    <= IDLE;
          busy     <= 1'b0;
          player_o <= (player_o == PW'(NPLAYERS - 1)) ? '0 : player_o + 1'b1;
        end else begin
          state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_choose_multi.sv
// Scoreboard bench for choose_multi: stimulus pushes expected resolutions, a monitor checks each pulse.
module tb_choose_multi;
  import choose_pkg::*;

  localparam int NW = 3;
  localparam int SW = 5;
  localparam int PW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pulse_i;
  logic [NW-1:0] num;
  logic          choice;
  logic          confirm;
  logic [1:0]    result;
  logic          pulse_o;
  logic [SW-1:0] score_o;
  logic [PW-1:0] player_o;
  logic          busy;

  typedef struct packed {
    logic [1:0]    res;
    logic [SW-1:0] score;
    logic [PW-1:0] player;
  } exp_t;

  exp_t sb[$];
  int   errors      = 0;
  int   checks      = 0;
  int   pulses_seen = 0;
  int   pulses_exp  = 0;

  choose_multi #(
    .NPLAYERS(2), .TARGET(15), .NUM_W(NW), .SCORE_W(SW), .AUTO_FACE(6), .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_i  (pulse_i),
    .num      (num),
    .choice   (choice),
    .confirm  (confirm),
    .result   (result),
    .pulse_o  (pulse_o),
    .score_o  (score_o),
    .player_o (player_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input result_t r, input int s, input int p);
    exp_t e;
    e.res    = r;
    e.score  = SW'(s);
    e.player = PW'(p);
    sb.push_back(e);
    pulses_exp++;
  endtask

  task automatic do_reset();
    rst = 1'b1; pulse_i = 1'b0; confirm = 1'b0; choice = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic roll(input int n);
    @(negedge clk);
    pulse_i = 1'b1;
    num     = NW'(n);
    @(negedge clk);
    pulse_i = 1'b0;
  endtask

  task automatic wait_pulses();
    int budget = 0;
    while (pulses_seen < pulses_exp && budget < 60) begin
      tick(1);
      budget++;
    end
    if (pulses_seen < pulses_exp) begin
      errors++;
      checks++;
      $display("[TB] FAIL pulse_wait: got %0d pulses, expected %0d", pulses_seen, pulses_exp);
      pulses_seen = pulses_exp;
    end
  endtask

  task automatic apply_stimulus(input int n, input logic ch, input int hold);
    roll(n);
    tick(1);
    confirm = 1'b1;
    tick(hold);
    choice  = ch;
    confirm = 1'b0;
    wait_pulses();
  endtask

  // Monitor: every resolution strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (pulse_o) begin
      pulses_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got result=%0d score=%0d player=%0d, expected no pulse",
                 result, score_o, player_o);
      end else begin
        e = sb.pop_front();
        check_output("pulse_result", int'(result), int'(e.res));
        check_output("pulse_score", int'(score_o), int'(e.score));
        check_output("pulse_player", int'(player_o), int'(e.player));
      end
    end
  end

  initial begin
    rst = 1'b1; pulse_i = 1'b0; num = '0; choice = 1'b0; confirm = 1'b0;
    tick(3);
    rst = 1'b0;
    check_output("reset_player", int'(player_o), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_score", int'(score_o), 0);
    check_output("reset_result", int'(result), 0);

    // Auto-keep with exact latency
    push(CONTINUE, 6, 1);
    roll(6);
    check_output("auto_busy", int'(busy), 1);
    check_output("auto_early", int'(pulse_o), 0);
    tick(1);
    check_output("auto_latency", int'(pulse_o), 1);
    wait_pulses();
    tick(2);
    check_output("score_hold", int'(score_o), 6);
    check_output("result_idle", int'(result), 0);
    check_output("idle_busy", int'(busy), 0);

    // Player choice: keep, then discard
    push(CONTINUE, 3, 0);
    apply_stimulus(3, 1'b1, 3);
    push(CONTINUE, 6, 1);
    apply_stimulus(3, 1'b0, 3);

    // Build player 0 to 9, then auto-win
    push(CONTINUE, 5, 0);  apply_stimulus(2, 1'b1, 1);
    push(CONTINUE, 9, 1);  apply_stimulus(3, 1'b1, 2);
    push(CONTINUE, 5, 0);  apply_stimulus(0, 1'b1, 1);
    push(WON, 15, 0);      roll(6); wait_pulses();
    roll(6);
    tick(6);
    check_output("done_busy", int'(busy), 1);
    check_output("done_no_pulse", pulses_seen, pulses_exp);
    check_output("done_player", int'(player_o), 0);

    // Overshoot to LOST
    do_reset();
    check_output("reset2_player", int'(player_o), 0);
    push(CONTINUE, 6, 1);  roll(6); wait_pulses();
    push(CONTINUE, 6, 0);  roll(6); wait_pulses();
    push(CONTINUE, 12, 1); roll(6); wait_pulses();
    push(CONTINUE, 10, 0); apply_stimulus(4, 1'b1, 1);
    push(LOST, 0, 0);      apply_stimulus(5, 1'b1, 1);
    tick(1);
    check_output("lost_busy", int'(busy), 1);

    // Exact hit from 10 via choice
    do_reset();
    push(CONTINUE, 6, 1);  roll(6); wait_pulses();
    push(CONTINUE, 0, 0);  apply_stimulus(1, 1'b0, 1);
    push(CONTINUE, 10, 1); apply_stimulus(4, 1'b1, 1);
    push(CONTINUE, 0, 0);  apply_stimulus(1, 1'b0, 1);
    push(WON, 15, 0);      apply_stimulus(5, 1'b1, 1);

    // Timeout discard with confirm already high on entry
    do_reset();
    confirm = 1'b1;
    push(CONTINUE, 0, 1);
    roll(4);
    tick(8);
    check_output("timeout_early", int'(pulse_o), 0);
    tick(1);
    check_output("timeout_pulse", int'(pulse_o), 1);
    confirm = 1'b0;
    wait_pulses();

    // Confirm edge on the expiry cycle wins
    roll(2);
    tick(8);
    confirm = 1'b1;
    tick(1);
    check_output("edge_beats_timeout", int'(pulse_o), 0);
    check_output("edge_busy", int'(busy), 1);
    tick(2);
    push(CONTINUE, 2, 0);
    choice  = 1'b1;
    confirm = 1'b0;
    wait_pulses();

    // Reset while in RELEASE drops the resolution and clears scores
    roll(5);
    tick(1);
    confirm = 1'b1;
    choice  = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    confirm = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    check_output("rst_rel_pulse", int'(pulse_o), 0);
    check_output("rst_rel_player", int'(player_o), 0);
    check_output("rst_rel_score", int'(score_o), 0);
    check_output("rst_rel_busy", int'(busy), 0);
    push(CONTINUE, 6, 1); roll(6); wait_pulses();
    push(CONTINUE, 6, 0); roll(6); wait_pulses();

    tick(3);
    check_output("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
